line_buf_ctrl: RTL and testbench
================================

# line_buf_ctrl

Parametrised double-buffered line store that accepts one pixel per write strobe at an explicit address, commits complete lines, and streams them to downstream converter channels in groups of 1 to LANES_MAX pixels per beat, in forward or reversed order. It sits between the input pixel interface and the per-channel data converters. It replaces a fixed 720-pixel, 2/3-lane, single-bank controller with a generic version that has several additions:
- two banks, so writing never corrupts a line being read;
- a valid/ready handshake;
- a partial-final-group mask;
- overflow detection.

## Interface
Parameters:
- DATA_W, 8, pixel width in bits
- LINE_LEN, 720, pixels per line (2..4096)
- LANES_MAX, 3, output lanes (1..4)
- AW, $clog2(LINE_LEN), write address width (derived, not overridden)

Ports:
- CLK  in  1  single clock, all logic on rising edge
- RSTN  in  1  reset, asynchronous assert, active-low
- i_WE  in  1  write strobe
- i_ADDR  in  AW  pixel index within line, 0..LINE_LEN-1
- i_DATA  in  DATA_W  pixel
- i_EOL  in  1  commit current write bank as a complete line (may coincide with i_WE; that write lands first)
- i_LANES  in  2  lanes per beat minus 1; values ≥ LANES_MAX clamp to LANES_MAX-1
- i_REV  in  1  reverse readout order
- i_READY  in  1  downstream accepts beat
- o_DATA  out  LANES_MAX*DATA_W  lane 0 in LSBs
- o_KEEP  out  LANES_MAX  lane-valid mask
- o_VALID  out  1  beat valid
- o_SOL / o_EOL  out  1  first / last beat of a line
- o_FULL  out  1  both banks committed, writes blocked
- o_OVF  out  1  sticky overflow error

## Operation
Banks and writes:
- Two banks, write bank index wb, read bank index rb, committed count cnt (0..2).
- A write with i_ADDR ≥ LINE_LEN is ignored (no error).
- Commit (i_EOL while cnt<2):
  - latches lanes and rev for that bank;
  - cnt+1;
  - wb toggles.
- Write or i_EOL while cnt==2: ignored, o_OVF set until reset.

Read FSM states:
- IDLE: if cnt>0, go to LOAD.
- LOAD:
  - ptr = 0 (forward) or LINE_LEN-1 (reverse);
  - rem = LINE_LEN;
  - go to STREAM.
- STREAM:
  - Beat: lane k = bank[ptr±k] for k < min(L, rem), where L = latched lanes+1; other lanes are 0 with o_KEEP=0.
  - On o_VALID && i_READY: ptr ±= L, rem -= L.
  - When the accepted beat had rem ≤ L: release bank (cnt-1, rb toggles), go to LOAD if cnt after release > 0, else IDLE.

Handshake and flags:
- o_DATA/o_KEEP/o_SOL/o_EOL hold while o_VALID && !i_READY.
- o_SOL is high on the first beat of a line, o_EOL on the last.
- Commit and release in the same cycle leave cnt unchanged.
- o_FULL = (cnt==2).

Arithmetic:
- ptr and rem are AW+1 bits unsigned, so they never wrap.
- Reverse indices stay ≥ 0 because lanes with k ≥ rem are masked.

Reset:
- Asynchronous, clears cnt, wb, rb, FSM, o_OVF.
- Bank contents are undefined.
- Asserting reset mid-line abandons the line with no final beat.

## Timing
- Reset values: o_DATA=0, o_KEEP=0, o_VALID=0, o_SOL=0, o_EOL=0, o_FULL=0, o_OVF=0.
- Commit on edge n with the reader IDLE: IDLE→LOAD at n+1, o_VALID=1 after n+2.
- Back-to-back lines: one LOAD bubble cycle between the last beat of one line and the first beat of the next.
- With i_READY held high, throughput is L pixels per cycle.
- A line needs ceil(LINE_LEN/L) beats: 240 beats at L=3, 360 at L=2.
- Bank reads are combinational from registers into the output registers, so there is no extra read latency.
- o_FULL is registered and updates the cycle after the commit or release.

## Configuration
- LINE_BUF_REVERSE_EN defined:
  - i_REV is honoured as above;
  - the reverse pointer path is present.
- Not defined:
  - i_REV is ignored;
  - all lines stream forward;
  - the reverse adder and per-bank rev flag are removed.

## Structure
- Package line_buf_pkg holds:
  - FSM state enum (IDLE, LOAD, STREAM);
  - LANES_MAX limit constant 4;
  - per-bank config struct {lanes, rev}.
- Sub-module line_buf_bank, instantiated twice:
  - one write port;
  - LANES_MAX combinational read ports at consecutive (±) indices;
  - out-of-range index reads 0.

## Test plan
- Write 0..719 with data = addr[7:0], commit, i_LANES=2, i_REV=0, i_READY=1 → 240 beats. First beat {2,1,0} with o_SOL=1; last beat {0xCF,0xCE,0xCD} with o_EOL=1.
- LINE_LEN=10, L=3, i_REV=1 → beats {7,8,9}, {4,5,6}, {1,2,3}, then lane 0 = 0 with o_KEEP=3'b001 and o_EOL=1. Lane 0 is 9, 6, 3 per beat.
- Toggle i_READY with a 1/3 duty cycle → o_DATA stable while stalled, no pixel lost or duplicated (scoreboard).
- i_READY=0, commit two lines → o_FULL=1. A third write and i_EOL → o_OVF=1 and stored data unchanged. i_READY=1 → both lines stream, o_OVF stays 1.
- Deassert RSTN at beat 100 → all outputs 0 asynchronously. After release, a new line streams correctly from o_SOL.
- Build without LINE_BUF_REVERSE_EN, i_REV=1 → forward order output, identical to the first scenario.

Source files
------------

// File: rtl/line_buf_pkg.sv
// Shared types for the double-buffered line store: read FSM states and per-bank line config.
// Reverse readout support is compiled in with LINE_BUF_REVERSE_EN.
package line_buf_pkg;

    localparam int LANES_LIMIT = 4;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STREAM
    } rd_state_e;

    typedef struct packed {
        logic [1:0] lanes;
        logic       rev;
    } bank_cfg_t;

endpackage

// File: rtl/line_buf_bank.sv
// One line bank: single write port plus LANES_MAX combinational read ports at consecutive indices.
// With LINE_BUF_REVERSE_EN the read ports can walk downwards from the base pointer.
module line_buf_bank
    import line_buf_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int LINE_LEN  = 720,
    parameter int LANES_MAX = 3,
    parameter int AW        = $clog2(LINE_LEN)
) (
    input  logic                                clk,
    input  logic                                we,
    input  logic [AW-1:0]                       waddr,
    input  logic [DATA_W-1:0]                   wdata,
    input  logic [AW:0]                         rptr,
`ifdef LINE_BUF_REVERSE_EN
    input  logic                                rev,
`endif
    output logic [LANES_MAX-1:0][DATA_W-1:0]    rdata
);

    logic [DATA_W-1:0] mem [LINE_LEN];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // One extra index bit so that a reverse step below zero wraps far above LINE_LEN and reads 0.
    for (genvar k = 0; k < LANES_MAX; k++) begin : g_rd
        logic [AW+1:0] idx;
`ifdef LINE_BUF_REVERSE_EN
        assign idx = rev ? ({1'b0, rptr} - (AW+2)'(k)) : ({1'b0, rptr} + (AW+2)'(k));
`else
        assign idx = {1'b0, rptr} + (AW+2)'(k);
`endif
        assign rdata[k] = (idx < (AW+2)'(LINE_LEN)) ? mem[idx[AW-1:0]] : '0;
    end

endmodule

// File: rtl/line_buf_ctrl.sv
// Double-buffered line store streaming committed lines in groups of 1..LANES_MAX pixels per beat.
// Define LINE_BUF_REVERSE_EN to honour i_REV (reversed readout); otherwise all lines stream forward.
module line_buf_ctrl
    import line_buf_pkg::*;
#(
    parameter int  DATA_W    = 8,
    parameter int  LINE_LEN  = 720,
    parameter int  LANES_MAX = 3,
    localparam int AW        = $clog2(LINE_LEN)
) (
    input  logic                        CLK,
    input  logic                        RSTN,
    input  logic                        i_WE,
    input  logic [AW-1:0]               i_ADDR,
    input  logic [DATA_W-1:0]           i_DATA,
    input  logic                        i_EOL,
    input  logic [1:0]                  i_LANES,
    input  logic                        i_REV,
    input  logic                        i_READY,
    output logic [LANES_MAX*DATA_W-1:0] o_DATA,
    output logic [LANES_MAX-1:0]        o_KEEP,
    output logic                        o_VALID,
    output logic                        o_SOL,
    output logic                        o_EOL,
    output logic                        o_FULL,
    output logic                        o_OVF
);

    localparam int PW = AW + 1;

    rd_state_e                          state, state_nx;
    logic [1:0]                         cnt, cnt_nx;
    logic                               wb, rb;
    logic [PW-1:0]                      ptr, ptr_nx, rem, rem_nx, lanes_n;
    logic [1:0]                         lanes_c, cur_lanes;
    logic                               blocked, commit, wr_ok, accept, rel, load_beat, sol_nx;
    logic [LANES_MAX-1:0][DATA_W-1:0]   rd [2];
    logic [LANES_MAX-1:0][DATA_W-1:0]   beat_data, data_q;
    logic [LANES_MAX-1:0]               beat_keep;

    assign lanes_c = ({1'b0, i_LANES} >= 3'(LANES_MAX)) ? 2'(LANES_MAX - 1) : i_LANES;
    assign blocked = (cnt == 2'd2);
    assign commit  = i_EOL && !blocked;
    assign wr_ok   = i_WE && !blocked && (32'(i_ADDR) < LINE_LEN);
    assign accept  = o_VALID && i_READY;

`ifdef LINE_BUF_REVERSE_EN
    bank_cfg_t cfg [2];
    logic      cur_rev;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            cfg[0] <= '0;
            cfg[1] <= '0;
        end else if (commit) begin
            cfg[wb] <= '{lanes: lanes_c, rev: i_REV};
        end
    end
    assign cur_lanes = cfg[rb].lanes;
    assign cur_rev   = cfg[rb].rev;
`else
    logic [1:0] cfg_lanes [2];
    logic       unused_rev;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            cfg_lanes[0] <= '0;
            cfg_lanes[1] <= '0;
        end else if (commit) begin
            cfg_lanes[wb] <= lanes_c;
        end
    end
    assign cur_lanes  = cfg_lanes[rb];
    assign unused_rev = i_REV;
`endif

    assign lanes_n = PW'(cur_lanes) + PW'(1);

    for (genvar b = 0; b < 2; b++) begin : g_bank
        line_buf_bank #(
            .DATA_W    (DATA_W),
            .LINE_LEN  (LINE_LEN),
            .LANES_MAX (LANES_MAX),
            .AW        (AW)
        ) u_bank (
            .clk   (CLK),
            .we    (wr_ok && (wb == 1'(b))),
            .waddr (i_ADDR),
            .wdata (i_DATA),
            .rptr  (ptr_nx),
`ifdef LINE_BUF_REVERSE_EN
            .rev   (cur_rev),
`endif
            .rdata (rd[b])
        );
    end

    always_comb begin
        state_nx  = state;
        ptr_nx    = ptr;
        rem_nx    = rem;
        rel       = 1'b0;
        load_beat = 1'b0;
        sol_nx    = 1'b0;
        case (state)
            IDLE: if (cnt != 2'd0) state_nx = LOAD;
            LOAD: begin
`ifdef LINE_BUF_REVERSE_EN
                ptr_nx = cur_rev ? PW'(LINE_LEN - 1) : '0;
`else
                ptr_nx = '0;
`endif
                rem_nx    = PW'(LINE_LEN);
                load_beat = 1'b1;
                sol_nx    = 1'b1;
                state_nx  = STREAM;
            end
            STREAM: if (accept) begin
                if (rem <= lanes_n) begin
                    // Bank freed this cycle; a same-cycle commit keeps another line pending.
                    rel      = 1'b1;
                    state_nx = (cnt > 2'd1 || commit) ? LOAD : IDLE;
                end else begin
`ifdef LINE_BUF_REVERSE_EN
                    ptr_nx = cur_rev ? (ptr - lanes_n) : (ptr + lanes_n);
`else
                    ptr_nx = ptr + lanes_n;
`endif
                    rem_nx    = rem - lanes_n;
                    load_beat = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        beat_data = '0;
        beat_keep = '0;
        for (int k = 0; k < LANES_MAX; k++) begin
            if (PW'(k) < lanes_n && PW'(k) < rem_nx) begin
                beat_keep[k] = 1'b1;
                beat_data[k] = rd[rb][k];
            end
        end
    end

    assign cnt_nx = cnt + 2'(commit) - 2'(rel);

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state  <= IDLE;
            cnt    <= '0;
            wb     <= 1'b0;
            rb     <= 1'b0;
            ptr    <= '0;
            rem    <= '0;
            o_FULL <= 1'b0;
            o_OVF  <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            ptr    <= ptr_nx;
            rem    <= rem_nx;
            o_FULL <= (cnt_nx == 2'd2);
            if (commit) wb <= ~wb;
            if (rel)    rb <= ~rb;
            if ((i_WE || i_EOL) && blocked) o_OVF <= 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            o_VALID <= 1'b0;
            o_SOL   <= 1'b0;
            o_EOL   <= 1'b0;
            o_KEEP  <= '0;
            data_q  <= '0;
        end else if (load_beat) begin
            o_VALID <= 1'b1;
            o_SOL   <= sol_nx;
            o_EOL   <= (rem_nx <= lanes_n);
            o_KEEP  <= beat_keep;
            data_q  <= beat_data;
        end else if (accept) begin
            o_VALID <= 1'b0;
            o_SOL   <= 1'b0;
            o_EOL   <= 1'b0;
            o_KEEP  <= '0;
            data_q  <= '0;
        end
    end

    assign o_DATA = data_q;

endmodule

// File: tb/tb_line_buf_ctrl.sv
// Directed bench for line_buf_ctrl: a 720-pixel instance and a 10-pixel instance, each beat
// compared against a small line model. Expected order follows LINE_BUF_REVERSE_EN.
`timescale 1ns/1ps
module tb_line_buf_ctrl;

`ifdef LINE_BUF_REVERSE_EN
    localparam bit REV_EN = 1'b1;
`else
    localparam bit REV_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  addr0;
    logic [3:0]  addr1;
    logic [7:0]  din;
    logic [1:0]  lanes;
    logic        rev, ready;
    logic        we0, eolin0, we1, eolin1;
    logic [23:0] data0, data1;
    logic [2:0]  keep0, keep1;
    logic        vld0, vld1, sol0, sol1, eol0, eol1, full0, full1, ovf0, ovf1;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    line_buf_ctrl #(.DATA_W(8), .LINE_LEN(720), .LANES_MAX(3)) dut (
        .CLK(clk), .RSTN(rst_n), .i_WE(we0), .i_ADDR(addr0), .i_DATA(din), .i_EOL(eolin0),
        .i_LANES(lanes), .i_REV(rev), .i_READY(ready), .o_DATA(data0), .o_KEEP(keep0),
        .o_VALID(vld0), .o_SOL(sol0), .o_EOL(eol0), .o_FULL(full0), .o_OVF(ovf0)
    );

    line_buf_ctrl #(.DATA_W(8), .LINE_LEN(10), .LANES_MAX(3)) dut10 (
        .CLK(clk), .RSTN(rst_n), .i_WE(we1), .i_ADDR(addr1), .i_DATA(din), .i_EOL(eolin1),
        .i_LANES(lanes), .i_REV(rev), .i_READY(ready), .o_DATA(data1), .o_KEEP(keep1),
        .o_VALID(vld1), .o_SOL(sol1), .o_EOL(eol1), .o_FULL(full1), .o_OVF(ovf1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] pix(input int pat, input int a);
        case (pat)
            0:       return 8'(a);
            1:       return 8'(a * 7 + 3);
            default: return ~8'(a);
        endcase
    endfunction

    task automatic write_line(input int which, input int ll, input int pat, input bit commit);
        for (int a = 0; a < ll; a++) begin
            addr0 = 10'(a);
            addr1 = 4'(a);
            din   = pix(pat, a);
            if (which == 0) begin
                we0 = 1'b1; eolin0 = commit && (a == ll - 1);
            end else begin
                we1 = 1'b1; eolin1 = commit && (a == ll - 1);
            end
            step;
        end
        we0 = 1'b0; eolin0 = 1'b0; we1 = 1'b0; eolin1 = 1'b0;
    endtask

    // Walks one line through the model; counts beats accepted and beats that differ from it.
    task automatic stream_line(input int which, input int ll, input int lsz, input bit rv,
                               input int pat, input bit duty3, input int abort_at,
                               output int beats, output int errs,
                               output logic [23:0] f_data, output logic f_sol,
                               output logic [23:0] l_data, output logic [2:0] l_keep,
                               output logic l_eol);
        int          ptr, rem, cyc;
        bit          done, rdy;
        logic        v, s, e;
        logic [23:0] d, ed;
        logic [2:0]  kp, ek;
        ptr = rv ? ll - 1 : 0;
        rem = ll;
        beats = 0; errs = 0; cyc = 0; done = 1'b0;
        f_data = '0; f_sol = 1'b0; l_data = '0; l_keep = '0; l_eol = 1'b0;
        while (!done && cyc < 4000) begin
            rdy   = duty3 ? (cyc % 3 == 0) : 1'b1;
            ready = rdy;
            if (which == 0) begin
                v = vld0; s = sol0; e = eol0; d = data0; kp = keep0;
            end else begin
                v = vld1; s = sol1; e = eol1; d = data1; kp = keep1;
            end
            if (v) begin
                ed = '0; ek = '0;
                for (int k = 0; k < lsz; k++) begin
                    if (k < rem) begin
                        ek[k] = 1'b1;
                        ed[k*8 +: 8] = pix(pat, rv ? ptr - k : ptr + k);
                    end
                end
                if (d !== ed || kp !== ek || s !== (rem == ll) || e !== (rem <= lsz)) errs++;
                if (rdy) begin
                    if (beats == 0) begin
                        f_data = d; f_sol = s;
                    end
                    l_data = d; l_keep = kp; l_eol = e;
                    beats++;
                    if (rem <= lsz) done = 1'b1;
                    else begin
                        ptr = rv ? ptr - lsz : ptr + lsz;
                        rem = rem - lsz;
                    end
                    if (beats == abort_at) break;
                end
            end
            step;
            cyc++;
        end
        if (!done && beats != abort_at) errs++;
    endtask

    int          beats, errs;
    logic [23:0] f_data, l_data;
    logic        f_sol, l_eol;
    logic [2:0]  l_keep;

    initial begin
        addr0 = '0; addr1 = '0; din = '0; lanes = '0; rev = 1'b0; ready = 1'b0;
        we0 = 1'b0; eolin0 = 1'b0; we1 = 1'b0; eolin1 = 1'b0;
        repeat (3) step;
        chk("rst_data", data0, 0);
        chk("rst_keep", keep0, 0);
        chk("rst_valid", vld0, 0);
        chk("rst_sol", sol0, 0);
        chk("rst_eol", eol0, 0);
        chk("rst_full", full0, 0);
        chk("rst_ovf", ovf0, 0);
        rst_n = 1'b1;
        step;

        // Forward 720-pixel line, three lanes
        lanes = 2'd2; rev = 1'b0; ready = 1'b1;
        write_line(0, 720, 0, 1'b1);
        chk("lat_commit", vld0, 0);
        step;
        chk("lat_load", vld0, 0);
        step;
        chk("lat_valid", vld0, 1);
        stream_line(0, 720, 3, 1'b0, 0, 1'b0, -1, beats, errs, f_data, f_sol, l_data, l_keep, l_eol);
        chk("fwd_beats", beats, 240);
        chk("fwd_errs", errs, 0);
        chk("fwd_first", f_data, 24'h020100);
        chk("fwd_sol", f_sol, 1);
        chk("fwd_last", l_data, 24'hCFCECD);
        chk("fwd_eol", l_eol, 1);

        // Ten-pixel line, three lanes, reverse request with a partial final group
        lanes = 2'd2; rev = 1'b1;
        write_line(1, 10, 0, 1'b1);
        stream_line(1, 10, 3, REV_EN, 0, 1'b0, -1, beats, errs, f_data, f_sol, l_data, l_keep, l_eol);
        chk("rev_beats", beats, 4);
        chk("rev_errs", errs, 0);
        chk("rev_first", f_data, REV_EN ? 24'h070809 : 24'h020100);
        chk("rev_last", l_data, REV_EN ? 24'h000000 : 24'h000009);
        chk("rev_keep", l_keep, 3'b001);

        // Two lanes with downstream ready at 1/3 duty: beats must hold while stalled
        lanes = 2'd1; rev = 1'b0;
        write_line(1, 10, 1, 1'b1);
        stream_line(1, 10, 2, 1'b0, 1, 1'b1, -1, beats, errs, f_data, f_sol, l_data, l_keep, l_eol);
        chk("stall_beats", beats, 5);
        chk("stall_errs", errs, 0);

        // Fill both banks, then overflow; lane request 3 clamps to 3 lanes
        ready = 1'b0; lanes = 2'd3; rev = 1'b0;
        write_line(0, 720, 0, 1'b1);
        rev = 1'b1;
        write_line(0, 720, 1, 1'b1);
        chk("full_set", full0, 1);
        chk("ovf_clear", ovf0, 0);
        addr0 = '0; din = 8'hEE; we0 = 1'b1; eolin0 = 1'b1;
        step;
        we0 = 1'b0; eolin0 = 1'b0;
        chk("ovf_set", ovf0, 1);
        chk("full_hold", full0, 1);
        stream_line(0, 720, 3, 1'b0, 0, 1'b0, -1, beats, errs, f_data, f_sol, l_data, l_keep, l_eol);
        chk("ovfA_beats", beats, 240);
        chk("ovfA_errs", errs, 0);
        chk("ovfA_first", f_data, 24'h020100);
        stream_line(0, 720, 3, REV_EN, 1, 1'b0, -1, beats, errs, f_data, f_sol, l_data, l_keep, l_eol);
        chk("ovfB_beats", beats, 240);
        chk("ovfB_errs", errs, 0);
        chk("ovf_sticky", ovf0, 1);
        chk("full_clear", full0, 0);

        // Reset in the middle of a line, then a fresh line
        lanes = 2'd2; rev = 1'b0;
        write_line(0, 720, 2, 1'b1);
        stream_line(0, 720, 3, 1'b0, 2, 1'b0, 100, beats, errs, f_data, f_sol, l_data, l_keep, l_eol);
        chk("pre_rst_beats", beats, 100);
        chk("pre_rst_errs", errs, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", vld0, 0);
        chk("arst_data", data0, 0);
        chk("arst_keep", keep0, 0);
        chk("arst_sol", sol0, 0);
        chk("arst_eol", eol0, 0);
        chk("arst_ovf", ovf0, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step;
        rev = 1'b1;
        write_line(0, 720, 1, 1'b1);
        stream_line(0, 720, 3, REV_EN, 1, 1'b0, -1, beats, errs, f_data, f_sol, l_data, l_keep, l_eol);
        chk("post_rst_beats", beats, 240);
        chk("post_rst_errs", errs, 0);
        chk("post_rst_sol", f_sol, 1);
        chk("d10_full", full1, 0);
        chk("d10_ovf", ovf1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
